// File: rtl/dma_xfer_sequencer.sv
// DMA front-end: splits one request into MAX_CHUNK-boundary-safe chunks, issues
// paired reader/writer commands, tracks outstanding statuses, reports one completion.
module dma_xfer_sequencer #(
  parameter int ADDR_W          = 64,
  parameter int LEN_W           = 32,
  parameter int MAX_CHUNK       = 4096,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CL_W            = $clog2(MAX_CHUNK) + 1
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_src,
  input  logic [ADDR_W-1:0] req_dst,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rd_cmd_valid,
  input  logic              rd_cmd_ready,
  output logic [ADDR_W-1:0] rd_cmd_addr,
  output logic [CL_W-1:0]   rd_cmd_len,
  output logic              wr_cmd_valid,
  input  logic              wr_cmd_ready,
  output logic [ADDR_W-1:0] wr_cmd_addr,
  output logic [CL_W-1:0]   wr_cmd_len,
  input  logic              rd_stat_valid,
  output logic              rd_stat_ready,
  input  logic              rd_stat_err,
  input  logic              wr_stat_valid,
  output logic              wr_stat_ready,
  input  logic              wr_stat_err,
  output logic              done_valid,
  input  logic              done_ready,
  output logic              done_err,
  output logic              busy
);
  localparam int OFF_W = $clog2(MAX_CHUNK);
  localparam int PW    = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_live;
  logic [ADDR_W-1:0] r_src, r_dst;
  logic [LEN_W-1:0]  r_rem, w_rem_nxt;
  logic              r_err, r_rd_sent, r_wr_sent;
  logic [PW-1:0]     r_rd_pend, r_wr_pend, w_rd_pend_nxt, w_wr_pend_nxt;
  logic [CL_W-1:0]   w_src_room, w_dst_room, w_rem_cap, w_chunk;
  logic              w_accept, w_req_bad, w_rd_hs, w_wr_hs;
  logic              w_rd_stat_hs, w_wr_stat_hs, w_chunk_done, w_stat_win;

  // r_live keeps every ready low during reset and for the first edge after release
  assign req_ready     = r_live && (r_state == S_IDLE);
  assign rd_stat_ready = r_live;
  assign wr_stat_ready = r_live;
  assign busy          = (r_state != S_IDLE);
  assign done_valid    = (r_state == S_DONE);
  assign done_err      = r_err;

  assign w_accept  = req_valid && req_ready;
  assign w_req_bad = (req_len == '0) || (|req_src[2:0]) || (|req_dst[2:0]) || (|req_len[2:0]);

  assign w_src_room = CL_W'(MAX_CHUNK) - {1'b0, r_src[OFF_W-1:0]};
  assign w_dst_room = CL_W'(MAX_CHUNK) - {1'b0, r_dst[OFF_W-1:0]};
  assign w_rem_cap  = (r_rem >= LEN_W'(MAX_CHUNK)) ? CL_W'(MAX_CHUNK) : r_rem[CL_W-1:0];

  always_comb begin
    w_chunk = w_rem_cap;
    if (w_src_room < w_chunk) w_chunk = w_src_room;
    if (w_dst_room < w_chunk) w_chunk = w_dst_room;
  end

  assign rd_cmd_valid = (r_state == S_ISSUE) && !r_rd_sent && (r_rd_pend < PW'(MAX_OUTSTANDING));
  assign wr_cmd_valid = (r_state == S_ISSUE) && !r_wr_sent && (r_wr_pend < PW'(MAX_OUTSTANDING));
  assign rd_cmd_addr  = r_src;
  assign wr_cmd_addr  = r_dst;
  assign rd_cmd_len   = w_chunk;
  assign wr_cmd_len   = w_chunk;

  assign w_rd_hs      = rd_cmd_valid && rd_cmd_ready;
  assign w_wr_hs      = wr_cmd_valid && wr_cmd_ready;
  assign w_rd_stat_hs = rd_stat_valid && rd_stat_ready;
  assign w_wr_stat_hs = wr_stat_valid && wr_stat_ready;
  assign w_stat_win   = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign w_chunk_done = (r_state == S_ISSUE) && (r_rd_sent || w_rd_hs) && (r_wr_sent || w_wr_hs);
  assign w_rem_nxt    = r_rem - LEN_W'(w_chunk);

  // a status with nothing pending is swallowed rather than underflowing
  always_comb begin
    w_rd_pend_nxt = r_rd_pend;
    if (w_rd_hs && !w_rd_stat_hs)                         w_rd_pend_nxt = r_rd_pend + 1'b1;
    else if (!w_rd_hs && w_rd_stat_hs && r_rd_pend != '0) w_rd_pend_nxt = r_rd_pend - 1'b1;
    w_wr_pend_nxt = r_wr_pend;
    if (w_wr_hs && !w_wr_stat_hs)                         w_wr_pend_nxt = r_wr_pend + 1'b1;
    else if (!w_wr_hs && w_wr_stat_hs && r_wr_pend != '0) w_wr_pend_nxt = r_wr_pend - 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_req_bad ? S_DONE : S_ISSUE;
      S_ISSUE: if (w_chunk_done && w_rem_nxt == '0) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_rd_pend_nxt == '0 && w_wr_pend_nxt == '0) w_state_nxt = S_DONE;
      S_DONE:  if (done_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= S_IDLE;
      r_live    <= 1'b0;
      r_src     <= '0;
      r_dst     <= '0;
      r_rem     <= '0;
      r_err     <= 1'b0;
      r_rd_sent <= 1'b0;
      r_wr_sent <= 1'b0;
      r_rd_pend <= '0;
      r_wr_pend <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_live    <= 1'b1;
      r_rd_pend <= w_rd_pend_nxt;
      r_wr_pend <= w_wr_pend_nxt;
      if (w_accept) begin
        r_src <= req_src;
        r_dst <= req_dst;
        r_rem <= req_len;
        r_err <= w_req_bad;
      end else begin
        if (w_chunk_done) begin
          r_src     <= r_src + ADDR_W'(w_chunk);
          r_dst     <= r_dst + ADDR_W'(w_chunk);
          r_rem     <= w_rem_nxt;
          r_rd_sent <= 1'b0;
          r_wr_sent <= 1'b0;
        end else begin
          if (w_rd_hs) r_rd_sent <= 1'b1;
          if (w_wr_hs) r_wr_sent <= 1'b1;
        end
        if (w_stat_win)
          r_err <= r_err | (w_rd_stat_hs & rd_stat_err) | (w_wr_stat_hs & wr_stat_err);
      end
    end
  end

endmodule

// File: tb/tb_dma_xfer_sequencer.sv
// Scoreboard bench for dma_xfer_sequencer: a chunking model fills expected queues,
// a negedge monitor pops and compares, a responder process plays reader/writer.
module tb_dma_xfer_sequencer;
  localparam int MC   = 4096;
  localparam int MO   = 4;
  localparam int CL_W = 13;
  localparam int BIG  = 1 << 30;

  typedef struct {
    logic [63:0]     addr;
    logic [CL_W-1:0] len;
  } cmd_t;

  logic            ACLK = 1'b0, ARESETn = 1'b0;
  logic            req_valid = 1'b0, req_ready;
  logic [63:0]     req_src = '0, req_dst = '0;
  logic [31:0]     req_len = '0;
  logic            rd_cmd_valid, rd_cmd_ready, wr_cmd_valid, wr_cmd_ready;
  logic [63:0]     rd_cmd_addr, wr_cmd_addr;
  logic [CL_W-1:0] rd_cmd_len, wr_cmd_len;
  logic            rd_stat_valid, rd_stat_ready, rd_stat_err;
  logic            wr_stat_valid, wr_stat_ready, wr_stat_err;
  logic            done_valid, done_ready, done_err, busy;

  dma_xfer_sequencer dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .req_len(req_len),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
    .wr_cmd_addr(wr_cmd_addr), .wr_cmd_len(wr_cmd_len),
    .rd_stat_valid(rd_stat_valid), .rd_stat_ready(rd_stat_ready), .rd_stat_err(rd_stat_err),
    .wr_stat_valid(wr_stat_valid), .wr_stat_ready(wr_stat_ready), .wr_stat_err(wr_stat_err),
    .done_valid(done_valid), .done_ready(done_ready), .done_err(done_err), .busy(busy)
  );

  always #5 ACLK = ~ACLK;

  int   n_chk = 0, n_fail = 0;
  cmd_t exp_rd[$], exp_wr[$];
  bit   exp_done[$];
  bit   rd_owed[$], wr_owed[$];
  int   err_side = 0, err_idx = -1, rd_idx = 0, wr_idx = 0;
  int   rd_hs_cnt = 0, wr_hs_cnt = 0, rd_out = 0, wr_out = 0;
  int   rd_allow = BIG, wr_allow = BIG, rd_stray = 0, wr_stray = 0;
  int   sink_mode = 0;  // 0 random, 1 always ready, 2 never ready
  bit   rd_stat_hs = 0, wr_stat_hs = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Monitor: every output handshake pops its expectation
  initial begin
    cmd_t e, rd_hv, wr_hv;
    bit   rd_hold = 0, wr_hold = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        rd_hold = 0; wr_hold = 0; rd_stat_hs = 0; wr_stat_hs = 0;
      end else begin
        if (rd_hold && rd_cmd_valid) begin
          chk("rd_cmd_stable_addr", rd_cmd_addr, rd_hv.addr);
          chk("rd_cmd_stable_len", 64'(rd_cmd_len), 64'(rd_hv.len));
        end
        if (wr_hold && wr_cmd_valid) begin
          chk("wr_cmd_stable_addr", wr_cmd_addr, wr_hv.addr);
          chk("wr_cmd_stable_len", 64'(wr_cmd_len), 64'(wr_hv.len));
        end
        rd_hold = rd_cmd_valid && !rd_cmd_ready; rd_hv.addr = rd_cmd_addr; rd_hv.len = rd_cmd_len;
        wr_hold = wr_cmd_valid && !wr_cmd_ready; wr_hv.addr = wr_cmd_addr; wr_hv.len = wr_cmd_len;
        if (rd_cmd_valid && rd_cmd_ready) begin
          if (exp_rd.size() == 0) fail_now("rd_cmd_unexpected");
          else begin
            e = exp_rd.pop_front();
            chk("rd_cmd_addr", rd_cmd_addr, e.addr);
            chk("rd_cmd_len", 64'(rd_cmd_len), 64'(e.len));
          end
          rd_owed.push_back(err_side == 1 && rd_idx == err_idx);
          rd_idx++; rd_hs_cnt++; rd_out++;
          chk("rd_outstanding_le_max", 64'(rd_out <= MO), 64'd1);
        end
        if (wr_cmd_valid && wr_cmd_ready) begin
          if (exp_wr.size() == 0) fail_now("wr_cmd_unexpected");
          else begin
            e = exp_wr.pop_front();
            chk("wr_cmd_addr", wr_cmd_addr, e.addr);
            chk("wr_cmd_len", 64'(wr_cmd_len), 64'(e.len));
          end
          wr_owed.push_back(err_side == 2 && wr_idx == err_idx);
          wr_idx++; wr_hs_cnt++; wr_out++;
          chk("wr_outstanding_le_max", 64'(wr_out <= MO), 64'd1);
        end
        rd_stat_hs = rd_stat_valid && rd_stat_ready;
        wr_stat_hs = wr_stat_valid && wr_stat_ready;
        if (rd_stat_hs && rd_out > 0) rd_out--;
        if (wr_stat_hs && wr_out > 0) wr_out--;
        if (done_valid && done_ready) begin
          if (exp_done.size() == 0) fail_now("done_unexpected");
          else chk("done_err", 64'(done_err), 64'(exp_done.pop_front()));
        end
      end
    end
  end

  // Responder: command sinks, status sources, completion sink
  initial begin
    bit rd_cur_stray = 0, wr_cur_stray = 0;
    rd_cmd_ready = 0; wr_cmd_ready = 0; done_ready = 0;
    rd_stat_valid = 0; rd_stat_err = 0; wr_stat_valid = 0; wr_stat_err = 0;
    forever begin
      @(posedge ACLK); #1;
      rd_cmd_ready = (sink_mode == 1) || (sink_mode == 0 && $urandom_range(0, 2) != 0);
      wr_cmd_ready = (sink_mode == 1) || (sink_mode == 0 && $urandom_range(0, 2) != 0);
      done_ready   = $urandom_range(0, 3) != 0;
      if (rd_stat_hs && !rd_cur_stray && rd_owed.size() > 0) begin void'(rd_owed.pop_front()); rd_allow--; end
      if (wr_stat_hs && !wr_cur_stray && wr_owed.size() > 0) begin void'(wr_owed.pop_front()); wr_allow--; end
      rd_stat_valid = 0; rd_stat_err = 0; wr_stat_valid = 0; wr_stat_err = 0;
      if (!ARESETn) continue;
      if (rd_stray > 0) begin
        rd_stat_valid = 1; rd_stat_err = 1; rd_cur_stray = 1; rd_stray--;
      end else if (rd_owed.size() > 0 && rd_allow > 0 && $urandom_range(0, 2) != 0) begin
        rd_stat_valid = 1; rd_stat_err = rd_owed[0]; rd_cur_stray = 0;
      end
      if (wr_stray > 0) begin
        wr_stat_valid = 1; wr_stat_err = 1; wr_cur_stray = 1; wr_stray--;
      end else if (wr_owed.size() > 0 && wr_allow > 0 && $urandom_range(0, 2) != 0) begin
        wr_stat_valid = 1; wr_stat_err = wr_owed[0]; wr_cur_stray = 0;
      end
    end
  end

  // Reference model: walk the request in boundary-safe chunks, then present it
  task automatic start_req(input logic [63:0] src, input logic [63:0] dst, input logic [31:0] len,
                           input int eside, input int eidx);
    logic [63:0] s = src, d = dst, r = 64'(len), c, rs, rdd;
    cmd_t        e;
    int          n = 0;
    bit          legal, got = 0;
    legal = (len != 0) && (src % 8 == 0) && (dst % 8 == 0) && (len % 8 == 0);
    while (legal && r > 0) begin
      rs  = 64'(MC) - (s % 64'(MC));
      rdd = 64'(MC) - (d % 64'(MC));
      c = r;
      if (rs < c) c = rs;
      if (rdd < c) c = rdd;
      e.addr = s; e.len = CL_W'(c); exp_rd.push_back(e);
      e.addr = d; exp_wr.push_back(e);
      s += c; d += c; r -= c; n++;
    end
    exp_done.push_back(!legal || (eside != 0 && eidx >= 0 && eidx < n));
    err_side = eside; err_idx = eidx; rd_idx = 0; wr_idx = 0; rd_hs_cnt = 0; wr_hs_cnt = 0;
    @(posedge ACLK); #1;
    req_valid = 1; req_src = src; req_dst = dst; req_len = len;
    for (int i = 0; i < 200; i++) begin
      @(negedge ACLK);
      if (req_ready) begin got = 1; break; end
    end
    @(posedge ACLK); #1;
    req_valid = 0;
    if (!got) fail_now("req_accept");
    @(negedge ACLK);
    if (legal) chk("first_cmd_valids_T1", {rd_cmd_valid, wr_cmd_valid}, 2'b11);
    else       chk("bad_req_done_T1", {done_valid, done_err, rd_cmd_valid, wr_cmd_valid}, 4'b1100);
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge ACLK);
      if (exp_done.size() == 0) begin got = 1; break; end
    end
    if (!got) fail_now("done_wait");
    chk("rd_cmds_left", 64'(exp_rd.size()), 64'd0);
    chk("wr_cmds_left", 64'(exp_wr.size()), 64'd0);
    exp_rd.delete(); exp_wr.delete(); exp_done.delete();
    @(posedge ACLK);
  endtask

  task automatic xfer(input logic [63:0] src, input logic [63:0] dst, input logic [31:0] len,
                      input int eside, input int eidx);
    start_req(src, dst, len, eside, eidx);
    wait_done();
  endtask

  initial begin
    bit got;
    #1;
    chk("reset_outputs", {req_ready, busy, rd_cmd_valid, wr_cmd_valid, done_valid,
                          rd_stat_ready, wr_stat_ready}, 7'b0);
    repeat (3) @(posedge ACLK);
    #2 ARESETn = 1;
    #1 chk("req_ready_before_edge", 64'(req_ready), 64'd0);
    @(posedge ACLK); #1;
    chk("req_ready_after_edge", {req_ready, busy}, 2'b10);

    sink_mode = 1;
    xfer(64'h1000, 64'h2000, 32'h40, 0, -1);
    sink_mode = 0;
    xfer(64'h0FF8, 64'h3000, 32'h1010, 0, -1);
    xfer(64'hFFFF_FFFF_FFFF_FFF0, 64'h0000_0000_0000_0FF0, 32'h20, 0, -1);

    // outstanding limit with statuses withheld
    sink_mode = 1; rd_allow = 0; wr_allow = 0;
    start_req(64'h0, 64'h10000, 32'h6000, 0, -1);
    repeat (12) @(negedge ACLK);
    chk("limit_rd_cmds", 64'(rd_hs_cnt), 64'd4);
    chk("limit_wr_cmds", 64'(wr_hs_cnt), 64'd4);
    chk("limit_valids_low", {rd_cmd_valid, wr_cmd_valid}, 2'b00);
    wr_allow = 1;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge ACLK); #2;
      if (wr_allow == 0) begin got = 1; break; end
    end
    if (!got) fail_now("limit_wr_stat");
    @(negedge ACLK);
    chk("limit_wr_reopens", {rd_cmd_valid, wr_cmd_valid}, 2'b01);
    rd_allow = BIG; wr_allow = BIG; sink_mode = 0;
    wait_done();

    // sticky error then clean
    xfer(64'h0, 64'h20000, 32'h3000, 2, 1);
    xfer(64'h0, 64'h20000, 32'h3000, 0, -1);

    // illegal requests
    xfer(64'h1000, 64'h2000, 32'h0, 0, -1);
    xfer(64'h1004, 64'h2000, 32'h40, 0, -1);

    // reset mid-transfer with a command held valid
    sink_mode = 2;
    start_req(64'h0, 64'h8000, 32'h3000, 0, -1);
    repeat (3) @(negedge ACLK);
    chk("pre_reset_valid", {rd_cmd_valid, wr_cmd_valid, busy}, 3'b111);
    @(posedge ACLK); #2;
    ARESETn = 0;
    #1 chk("reset_clears", {rd_cmd_valid, wr_cmd_valid, busy, req_ready, done_valid}, 5'b0);
    exp_rd.delete(); exp_wr.delete(); exp_done.delete(); rd_owed.delete(); wr_owed.delete();
    rd_out = 0; wr_out = 0;
    repeat (2) @(posedge ACLK);
    #2 ARESETn = 1;
    sink_mode = 0; rd_stray = 1; wr_stray = 1;
    repeat (5) @(posedge ACLK);
    xfer(64'h5000, 64'h9000, 32'h80, 0, -1);

    // randomized requests
    for (int t = 0; t < 25; t++) begin
      logic [63:0] s, d;
      logic [31:0] l;
      int es, ei, k;
      s  = 64'($urandom_range(0, 32'h7FFF)) << 3;
      d  = 64'($urandom_range(0, 32'h7FFF)) << 3;
      l  = 32'($urandom_range(1, 1400)) << 3;
      es = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0;
      ei = int'($urandom_range(0, 3));
      k  = int'($urandom_range(0, 11));
      if (k == 0) l = 0;
      else if (k == 1) s = s | 64'h4;
      else if (k == 2) d = d | 64'h2;
      else if (k == 3) l = l | 32'h4;
      xfer(s, d, l, es, ei);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_xfer_sequencer.md
# dma_xfer_sequencer

Front-end sequencer sitting directly upstream of the data mover. It accepts one DMA transfer request (source, destination, byte length) and splits it into chunks that never cross a MAX_CHUNK-aligned boundary on either side. For each chunk it issues a matching command pair to the reader and writer command channels, and tracks the returned reader/writer statuses. It reports one completion, with a sticky error flag, per request.

## Interface
- ADDR_W, 64, address width in bits
- LEN_W, 32, request length width in bytes
- MAX_CHUNK, 4096, maximum chunk size and boundary in bytes; power of two, ≥ 8
- MAX_OUTSTANDING, 4, max accepted-but-unacknowledged commands per side (reader and writer separately)
- CL_W (derived), $clog2(MAX_CHUNK)+1, chunk-length width

Ports:
- ACLK  in  1  clock; all logic is rising-edge
- ARESETn  in  1  asynchronous, active-low reset
- req_valid / req_ready  in / out  1  transfer request handshake
- req_src, req_dst  in  ADDR_W  byte addresses; must be 8-byte aligned
- req_len  in  LEN_W  byte count; must be a nonzero multiple of 8
- rd_cmd_valid / rd_cmd_ready  out / in  1  reader command handshake
- rd_cmd_addr  out  ADDR_W  chunk source address
- rd_cmd_len  out  CL_W  chunk bytes
- wr_cmd_valid / wr_cmd_ready  out / in  1  writer command handshake
- wr_cmd_addr  out  ADDR_W  chunk destination address
- wr_cmd_len  out  CL_W  chunk bytes
- rd_stat_valid / rd_stat_ready  in / out  1  reader status handshake
- rd_stat_err  in  1  reader chunk failed
- wr_stat_valid / wr_stat_ready  in / out  1  writer status handshake
- wr_stat_err  in  1  writer chunk failed
- done_valid / done_ready  out / in  1  completion handshake
- done_err  out  1  request completed with error
- busy  out  1  state ≠ IDLE

## Operation
- **States:** IDLE, ISSUE, DRAIN, DONE.
- **IDLE:** req_ready=1. On accept, latch cur_src, cur_dst, rem=req_len and clear err.
  - If req_len==0, or req_src[2:0]≠0, or req_dst[2:0]≠0, or req_len[2:0]≠0: set err and go to DONE. No commands are issued.
  - Otherwise go to ISSUE.
- **Chunk computation:** combinational from registers. chunk = min(rem, MAX_CHUNK − (cur_src mod MAX_CHUNK), MAX_CHUNK − (cur_dst mod MAX_CHUNK)). The rd and wr commands of a chunk always carry the same length.
- **ISSUE:**
  - rd_cmd_valid = !rd_sent && rd_pend < MAX_OUTSTANDING. wr_cmd_valid follows the same rule on the writer side.
  - A handshake sets that side's sent flag.
  - When both sides have been accepted (same cycle or different cycles): cur_src += chunk, cur_dst += chunk, rem −= chunk, and both sent flags clear.
  - If rem became 0, go to DRAIN.
  - Address addition wraps modulo 2^ADDR_W.
- **Pending counters:** rd_pend and wr_pend are each $clog2(MAX_OUTSTANDING+1) bits.
  - +1 on a command handshake, −1 on a status handshake; both in the same cycle leaves the counter unchanged.
  - A status arriving while the counter is 0 is accepted and ignored: no underflow, no error.
- **Status:** rd_stat_ready and wr_stat_ready are 1 in every state except during reset. err |= stat_err on any status handshake in ISSUE or DRAIN.
- **Errors:** errors do not stop issuing. Abort is out of scope.
- **DRAIN:** wait for rd_pend==0 && wr_pend==0, then go to DONE.
- **DONE:** done_valid=1, done_err=err, both held stable until done_ready. On the handshake go to IDLE.
- **Reset:** asserting ARESETn mid-operation clears everything immediately. State→IDLE; counters, flags and err→0.

## Timing
- **Reset values:** all outputs 0 while ARESETn is low, including req_ready, busy and every valid. req_ready is registered and rises on the first ACLK edge after deassertion.
- **Request to first command:** request accepted at edge T; rd_cmd_valid and wr_cmd_valid are asserted in cycle T+1.
- **Throughput:** at most one chunk per cycle. The next chunk's valids appear in the cycle after the chunk's final command handshake.
- **Command stability:** cmd addr and len are stable while the corresponding valid is high.
- **Completion:** done_valid rises the cycle after the status handshake that brings both counters to 0. For the error-at-accept case, done_valid rises the cycle after request accept.
- **Next request:** req_ready returns to 1 the cycle after the done handshake.

## Test plan
- **Single chunk:** src=0x1000, dst=0x2000, len=0x40, always-ready sinks → one rd cmd (0x1000, 0x40) and one wr cmd (0x2000, 0x40) at T+1; both stats returned ok → done_valid with done_err=0.
- **Boundary split:** src=0x0FF8, dst=0x3000, len=0x1010 → chunks in order 8, 0xFF8, 8, 8; rd addrs 0x0FF8, 0x1000, 0x1FF8, 0x2000; wr addrs 0x3000, 0x3008, 0x4000, 0x4008.
- **Outstanding limit:** aligned len=0x6000, statuses withheld → exactly 4 rd and 4 wr cmds, then both valids low. Return one wr stat → the 5th wr cmd is valid next cycle; rd stays blocked until a rd stat returns.
- **Sticky error:** 3-chunk transfer with wr_stat_err=1 on chunk 2 → all 3 chunk pairs still issued, done_err=1; the next clean request gives done_err=0.
- **Illegal request:** len=0, then src=0x1004 → no commands issued; done_valid with done_err=1 in cycle T+1 each time.
- **Reset mid-transfer:** ARESETn low during ISSUE with a command valid → all valids 0 immediately. After release, a new single-chunk request completes normally, and stray old statuses are ignored.
